// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, a registered
// carry and a start/busy/done handshake; one result every WIDTH+1 cycles.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_load;
    logic             w_last;

    // Next state plus the single full-adder cell working on the operand LSBs
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        w_sum  = r_opa[0] ^ r_opb[0] ^ r_carry;
        w_cout = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, datapath and registered outputs; subtract is a + ~b + 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            c       <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == RUN);
            done    <= (w_next == DONE);
            if (w_load) begin
                r_opa   <= a;
                r_opb   <= sub ? ~b : b;
                r_carry <= sub;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_opa   <= r_opa >> 1;
                r_opb   <= r_opb >> 1;
                r_carry <= w_cout;
                r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    s   <= {w_sum, r_acc[WIDTH-1:1]};
                    c   <= w_cout;
                    ovf <= r_carry ^ w_cout;
                end
            end
        end
    end

endmodule
